// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder block.
//   - Address constants for the memory-mapped registers (GPIO, TIMER, STATUS).
//   - Encoding of the two-state boot/run FSM.
package mem_responder_pkg;

  localparam logic [15:0] GPIO_ADDR   = 16'hFF00;
  localparam logic [15:0] TIMER_ADDR  = 16'hFF01;
  localparam logic [15:0] STATUS_ADDR = 16'hFF02;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU/loader side and the memory responder.
//
// CPU side:    address, we, data_in -> responder; data_out <- responder.
// Loader side: ld_valid, ld_addr, ld_data, ld_done -> responder;
//              ld_ready, ld_count <- responder.
// Status side: cpu_hold (CPU reset request) and gpio_out <- responder.
//
// The slave modport is the responder; the master modport is whoever drives
// the CPU and loader requests.
interface mem_responder_if;
  logic [15:0] address;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        cpu_hold;
  logic [15:0] ld_count;
  logic [31:0] gpio_out;

  modport slave (
    input  address, we, data_in, ld_valid, ld_addr, ld_data, ld_done,
    output data_out, ld_ready, cpu_hold, ld_count, gpio_out
  );

  modport master (
    output address, we, data_in, ld_valid, ld_addr, ld_data, ld_done,
    input  data_out, ld_ready, cpu_hold, ld_count, gpio_out
  );
endinterface

// File: rtl/mem_responder_ram_async.sv
// Word RAM with one write port on the rising clock edge and an asynchronous
// read port. Contents are never cleared; there is no reset.
//
// Ports:
//   clock  - write clock
//   we     - write enable
//   waddr  - write word index
//   wdata  - write data
//   raddr  - read word index
//   rdata  - read data, combinational from raddr
module ram_async #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: a word RAM plus GPIO, TIMER and STATUS registers, with a
// boot loader that fills memory while the CPU is held in reset.
//
// Ports:
//   clock, reset - system clock, synchronous active-high reset
//   bus          - CPU request/response, loader handshake, cpu_hold, gpio_out
//
// In BOOT the loader owns the write port and the CPU is held; ld_done moves
// the block to RUN, where the CPU owns the write port until the next reset.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam logic [31:0] DEPTH = 32'(1 << ADDR_BITS);

  // Only addresses below the RAM depth hit the RAM; nothing aliases.
  function automatic logic in_ram(input logic [15:0] a);
    return ({16'h0000, a} < DEPTH);
  endfunction

  state_t      state, state_next;
  logic        boot;
  logic        accept;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ram, wr_gpio, wr_timer;
  logic [15:0] ld_count;
  logic [31:0] gpio;
  logic [31:0] timer;
  logic [31:0] ram_rdata;
  logic [31:0] rd_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next state, handshake outputs and the loader/CPU write-port mux.
  always_comb begin
    state_next = state;
    boot       = (state == BOOT);
    accept     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = bus.address;
    wr_data    = bus.data_in;
    if (boot) begin
      accept  = bus.ld_valid;
      wr_en   = bus.ld_valid;
      wr_addr = bus.ld_addr;
      wr_data = bus.ld_data;
      if (bus.ld_done) begin
        state_next = RUN;
      end
    end else begin
      wr_en = bus.we;
    end
    // Reset wins over any write presented on the same edge.
    if (reset) begin
      wr_en = 1'b0;
    end
  end

  assign wr_ram   = wr_en && in_ram(wr_addr);
  assign wr_gpio  = wr_en && (wr_addr == GPIO_ADDR);
  assign wr_timer = wr_en && (wr_addr == TIMER_ADDR);

  always_ff @(posedge clock) begin
    if (reset) begin
      ld_count <= 16'h0000;
      gpio     <= 32'h0000_0000;
      timer    <= 32'h0000_0000;
    end else begin
      if (accept) begin
        ld_count <= ld_count + 16'd1;
      end
      if (wr_gpio) begin
        gpio <= wr_data;
      end
      // A write to TIMER replaces that cycle's increment.
      if (wr_timer) begin
        timer <= wr_data;
      end else if (!boot) begin
        timer <= timer + 32'd1;
      end
    end
  end

  ram_async #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clock(clock),
    .we   (wr_ram),
    .waddr(wr_addr[ADDR_BITS-1:0]),
    .wdata(wr_data),
    .raddr(bus.address[ADDR_BITS-1:0]),
    .rdata(ram_rdata)
  );

  // Zero-latency read decode; unmapped addresses read zero.
  always_comb begin
    rd_data = 32'h0000_0000;
    if (in_ram(bus.address)) begin
      rd_data = ram_rdata;
    end else begin
      case (bus.address)
        GPIO_ADDR:   rd_data = gpio;
        TIMER_ADDR:  rd_data = timer;
        STATUS_ADDR: rd_data = {ld_count, 15'h0000, (state == RUN)};
        default:     rd_data = 32'h0000_0000;
      endcase
    end
  end

  assign bus.data_out = rd_data;
  assign bus.ld_ready = boot;
  assign bus.cpu_hold = boot;
  assign bus.ld_count = ld_count;
  assign bus.gpio_out = gpio;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: loader boot, CPU register/RAM
// access, timer wrap, unmapped addresses, reset priority and reload.
module tb_mem_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [31:0] sb[$];

  mem_responder_if bus ();

  mem_responder #(
    .ADDR_BITS(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected read data is queued when the address is driven and checked
  // once data_out has settled.
  task automatic rd(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    sb.push_back(exp);
    bus.address = addr;
    #1;
    chk(tag, bus.data_out, sb.pop_front());
  endtask

  task automatic cpu_wr(input logic [15:0] addr, input logic [31:0] data);
    bus.we      = 1'b1;
    bus.address = addr;
    bus.data_in = data;
    step();
    bus.we      = 1'b0;
  endtask

  task automatic beat(input logic [15:0] addr, input logic [31:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    step();
    bus.ld_valid = 1'b0;
  endtask

  initial begin
    bus.address  = 16'h0;
    bus.we       = 1'b0;
    bus.data_in  = 32'h0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = 16'h0;
    bus.ld_data  = 32'h0;
    bus.ld_done  = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_hold",  32'(bus.cpu_hold), 32'd1);
    chk("rst_ready", 32'(bus.ld_ready), 32'd1);
    chk("rst_count", 32'(bus.ld_count), 32'd0);
    chk("rst_gpio",  bus.gpio_out, 32'h0);
    rd("rst_status", 16'hFF02, 32'h0);

    // Boot load of three beats
    beat(16'h0000, 32'h4000_0005);
    beat(16'h0001, 32'h1000_0010);
    beat(16'h0010, 32'h0000_0007);
    step();
    rd("boot_timer_held", 16'hFF01, 32'h0);
    bus.ld_done = 1'b1;
    chk("hold_before_done", 32'(bus.cpu_hold), 32'd1);
    step();
    bus.ld_done = 1'b0;
    chk("hold_after_done",  32'(bus.cpu_hold), 32'd0);
    chk("ready_run",        32'(bus.ld_ready), 32'd0);
    chk("load_count",       32'(bus.ld_count), 32'd3);
    rd("ram1", 16'h0001, 32'h1000_0010);
    rd("ram0", 16'h0000, 32'h4000_0005);
    rd("ram10", 16'h0010, 32'h0000_0007);
    rd("status_run", 16'hFF02, 32'h0003_0001);
    rd("timer_t0", 16'hFF01, 32'h0);
    step();
    rd("timer_t1", 16'hFF01, 32'h1);

    // GPIO write in RUN
    cpu_wr(16'hFF00, 32'hA5A5_A5A5);
    chk("gpio_out", bus.gpio_out, 32'hA5A5_A5A5);
    rd("gpio_rd", 16'hFF00, 32'hA5A5_A5A5);

    // Timer load wins over increment, then wraps
    cpu_wr(16'hFF01, 32'hFFFF_FFFE);
    rd("timer_load", 16'hFF01, 32'hFFFF_FFFE);
    step();
    rd("timer_ff", 16'hFF01, 32'hFFFF_FFFF);
    step();
    rd("timer_wrap", 16'hFF01, 32'h0);

    // Unmapped addresses, no aliasing, STATUS read-only, loader ignored in RUN
    rd("unmap_100",  16'h0100, 32'h0);
    rd("unmap_1234", 16'h1234, 32'h0);
    cpu_wr(16'h0100, 32'h1234_5678);
    rd("no_alias", 16'h0000, 32'h4000_0005);
    cpu_wr(16'hFF02, 32'hFFFF_FFFF);
    rd("status_ro", 16'hFF02, 32'h0003_0001);
    beat(16'h0001, 32'h0);
    chk("ld_ignored_cnt", 32'(bus.ld_count), 32'd3);
    rd("ld_ignored_ram", 16'h0001, 32'h1000_0010);
    cpu_wr(16'h0005, 32'hCAFE_F00D);
    rd("cpu_ram_wr", 16'h0005, 32'hCAFE_F00D);

    // Reset in RUN takes priority over a concurrent CPU write
    cpu_wr(16'hFF00, 32'h0000_00FF);
    chk("gpio_ff", bus.gpio_out, 32'h0000_00FF);
    reset       = 1'b1;
    bus.we      = 1'b1;
    bus.address = 16'h0000;
    bus.data_in = 32'h0000_0BAD;
    step();
    reset  = 1'b0;
    bus.we = 1'b0;
    chk("rrst_gpio",  bus.gpio_out, 32'h0);
    chk("rrst_hold",  32'(bus.cpu_hold), 32'd1);
    chk("rrst_count", 32'(bus.ld_count), 32'd0);
    rd("rrst_timer", 16'hFF01, 32'h0);
    rd("rrst_ram0",  16'h0000, 32'h4000_0005);

    // Reload: CPU writes ignored in BOOT, loader hits GPIO and unmapped space
    beat(16'h0002, 32'h2222_2222);
    cpu_wr(16'h0002, 32'h0000_DEAD);
    rd("boot_we_ign", 16'h0002, 32'h2222_2222);
    beat(16'hFF00, 32'h0000_005A);
    chk("ld_gpio", bus.gpio_out, 32'h0000_005A);
    beat(16'h4000, 32'h1111_1111);
    chk("ld_drop_cnt", 32'(bus.ld_count), 32'd3);

    // Reset wins over a beat with ld_done on the same edge
    reset        = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_done  = 1'b1;
    bus.ld_addr  = 16'h0002;
    bus.ld_data  = 32'h9999_9999;
    step();
    reset        = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_done  = 1'b0;
    rd("rprio_status", 16'hFF02, 32'h0);
    rd("rprio_ram2",   16'h0002, 32'h2222_2222);

    // Beat and ld_done on the same edge
    bus.ld_valid = 1'b1;
    bus.ld_done  = 1'b1;
    bus.ld_addr  = 16'h0003;
    bus.ld_data  = 32'h0000_0077;
    step();
    bus.ld_valid = 1'b0;
    bus.ld_done  = 1'b0;
    rd("same_ram3", 16'h0003, 32'h0000_0077);
    chk("same_count", 32'(bus.ld_count), 32'd1);
    chk("same_hold",  32'(bus.cpu_hold), 32'd0);
    rd("same_status", 16'hFF02, 32'h0001_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
